// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch front end.
package fetch_unit_pkg;

  localparam int                DEF_X_LENGTH    = 32;
  localparam logic [31:0]       DEF_RESET_PC    = 32'h0000_0000;
  localparam int                DEF_FIFO_DEPTH  = 2;
  localparam logic [31:0]       INST_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: PC tags are allocated at request accept, data is filled
// at response in the same order, and the head is read by decode.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int X_LENGTH = DEF_X_LENGTH,
  parameter int DEPTH    = DEF_FIFO_DEPTH
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           alloc,
  input  logic [X_LENGTH-1:0]            alloc_pc,
  input  logic                           fill,
  input  logic [31:0]                    fill_data,
  input  logic                           pop,
  output logic [X_LENGTH-1:0]            head_pc,
  output logic [31:0]                    head_data,
  output logic                           empty,
  output logic [$clog2(DEPTH):0]         count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] ONE_CNT = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] ONE_PTR = {{(PTR_W-1){1'b0}}, 1'b1};

  logic [X_LENGTH-1:0] tag_mem_r  [DEPTH];
  logic [31:0]         data_mem_r [DEPTH];
  logic [PTR_W-1:0]    alloc_ptr_r;
  logic [CNT_W-1:0]    fill_ptr_r;
  logic [CNT_W-1:0]    rd_ptr_r;

  // Pointer update; flush discards every tag and buffered word at once.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      alloc_ptr_r <= {PTR_W{1'b0}};
      fill_ptr_r  <= {CNT_W{1'b0}};
      rd_ptr_r    <= {CNT_W{1'b0}};
    end else begin
      if (alloc) alloc_ptr_r <= alloc_ptr_r + ONE_PTR;
      if (fill)  fill_ptr_r  <= fill_ptr_r + ONE_CNT;
      if (pop)   rd_ptr_r    <= rd_ptr_r + ONE_CNT;
    end
  end

  // Storage writes; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (alloc) tag_mem_r[alloc_ptr_r]          <= alloc_pc;
    if (fill)  data_mem_r[fill_ptr_r[PTR_W-1:0]] <= fill_data;
  end

  assign count     = fill_ptr_r - rd_ptr_r;
  assign empty     = (count == {CNT_W{1'b0}});
  assign head_pc   = tag_mem_r[rd_ptr_r[PTR_W-1:0]];
  assign head_data = data_mem_r[rd_ptr_r[PTR_W-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, credit-limited memory requests, wrong-path
// response dropping after redirect, and the decode-side valid/ready output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  X_LENGTH   = DEF_X_LENGTH,
  parameter logic [X_LENGTH-1:0] RESET_PC   = DEF_RESET_PC,
  parameter int                  FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [X_LENGTH-1:0] redirect_pc,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [X_LENGTH-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [31:0]         imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [X_LENGTH-1:0] inst_pc,
  output logic [31:0]         inst_data,
  output logic                fetch_misalign
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    ONE_CNT   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]      DEPTH_CNT = FIFO_DEPTH[CNT_W:0];
  localparam logic [X_LENGTH-1:0] PC_STEP   = X_LENGTH'(4);

  fetch_state_e        state_r, state_s;
  logic [X_LENGTH-1:0] fetch_pc_r, fetch_pc_s;
  logic [CNT_W-1:0]    outstanding_r, outstanding_s;
  logic [CNT_W-1:0]    drop_cnt_r, drop_cnt_s;
  logic [CNT_W-1:0]    fifo_count_s;
  logic [CNT_W:0]      in_use_s;
  logic                fifo_empty_s;
  logic                accept_s, fill_s, pop_s;
  logic                misalign_r;

  // Dropped-but-pending responses still occupy credit, so the buffer never overflows.
  assign in_use_s       = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
  assign imem_req_valid = rst_n && (state_r != S_BOOT) && !redirect_valid
                          && (in_use_s < DEPTH_CNT);
  assign imem_req_addr  = fetch_pc_r;
  assign accept_s       = imem_req_valid && imem_req_ready;
  assign inst_valid     = rst_n && !fifo_empty_s && !redirect_valid;
  assign pop_s          = inst_valid && inst_ready;
  assign fill_s         = imem_resp_valid && (drop_cnt_r == ZERO_CNT) && !redirect_valid;
  assign fetch_misalign = misalign_r;

  fetch_fifo #(
    .X_LENGTH (X_LENGTH),
    .DEPTH    (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .alloc     (accept_s),
    .alloc_pc  (fetch_pc_r),
    .fill      (fill_s),
    .fill_data (imem_resp_data),
    .pop       (pop_s),
    .head_pc   (inst_pc),
    .head_data (inst_data),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Next PC, in-flight and drop counters, and FSM transition.
  always_comb begin
    state_s       = state_r;
    fetch_pc_s    = fetch_pc_r;
    outstanding_s = outstanding_r;
    drop_cnt_s    = drop_cnt_r;

    case ({accept_s, imem_resp_valid})
      2'b10:   outstanding_s = outstanding_r + ONE_CNT;
      2'b01:   outstanding_s = outstanding_r - ONE_CNT;
      default: outstanding_s = outstanding_r;
    endcase

    if (redirect_valid) begin
      fetch_pc_s = {redirect_pc[X_LENGTH-1:2], 2'b00};
      drop_cnt_s = outstanding_s;
    end else begin
      if (accept_s) begin
        fetch_pc_s = fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_s = fetch_pc_r;
      end
      if (imem_resp_valid && (drop_cnt_r != ZERO_CNT)) begin
        drop_cnt_s = drop_cnt_r - ONE_CNT;
      end else begin
        drop_cnt_s = drop_cnt_r;
      end
    end

    case (state_r)
      S_BOOT:         state_s = S_RUN;
      S_RUN, S_DRAIN: state_s = (drop_cnt_s != ZERO_CNT) ? S_DRAIN : S_RUN;
      default:        state_s = S_BOOT;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= S_BOOT;
      fetch_pc_r    <= RESET_PC;
      outstanding_r <= ZERO_CNT;
      drop_cnt_r    <= ZERO_CNT;
      misalign_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      fetch_pc_r    <= fetch_pc_s;
      outstanding_r <= outstanding_s;
      drop_cnt_r    <= drop_cnt_s;
      misalign_r    <= redirect_valid && is_misaligned(redirect_pc[1:0]);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a random phase,
// compared against a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n, redirect_valid, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, inst_valid, inst_ready, fetch_misalign;
  logic [31:0] redirect_pc, imem_req_addr, imem_resp_data, inst_pc, inst_data;

  always #5 clk = ~clk;

  fetch_unit #(.X_LENGTH(32), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_pc(inst_pc), .inst_data(inst_data),
    .fetch_misalign(fetch_misalign)
  );

  typedef struct {
    logic [31:0] mem_addr;
    logic [31:0] exp_pc;
    int          earliest;
    int          epoch;
  } mreq_t;

  mreq_t       mq[$];       // accepted requests awaiting their response
  logic [31:0] buf_q[$];    // right-path words delivered, not yet consumed
  logic [31:0] pop_log[$];
  logic [31:0] acc_log[$];
  logic [31:0] m_pc;
  bit          m_boot, m_mis;
  int          epoch, cyc, lat_max, resp_pct;
  int          errors, checks, accepts, mis_pulses, first_iv;
  logic        c_req_valid, c_inst_valid;
  logic [31:0] c_addr, c_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input bit use_acc, input int idx, input logic [31:0] exp);
    logic [31:0] obs;
    obs = 32'hxxxx_xxxx;
    if (use_acc && acc_log.size() > idx) obs = acc_log[idx];
    else if (!use_acc && pop_log.size() > idx) obs = pop_log[idx];
    else obs = 32'hxxxx_xxxx;
    chk(tag, obs, exp);
  endtask

  // One clock: check outputs mid-cycle, update the model at the edge, drive memory.
  task automatic cycle();
    logic  exp_rv, exp_iv;
    mreq_t e;
    @(negedge clk);
    c_req_valid  = imem_req_valid;
    c_inst_valid = inst_valid;
    c_addr       = imem_req_addr;
    c_pc         = inst_pc;
    exp_rv = rst_n && !m_boot && !redirect_valid && ((mq.size() + buf_q.size()) < DEPTH);
    exp_iv = rst_n && (buf_q.size() != 0) && !redirect_valid;
    chk("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, exp_iv});
    chk("misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});
    if (fetch_misalign) mis_pulses++;
    if (imem_req_valid && exp_rv) chk("req_addr", imem_req_addr, m_pc);
    if (inst_valid && exp_iv) begin
      chk("inst_pc", inst_pc, buf_q[0]);
      chk("inst_data", inst_data, memf(buf_q[0]));
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mq.delete();
      buf_q.delete();
      m_pc   = RPC;
      m_boot = 1'b1;
      m_mis  = 1'b0;
    end else begin
      m_boot = 1'b0;
      m_mis  = redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (c_inst_valid && inst_ready) begin
        pop_log.push_back(c_pc);
        if (buf_q.size() != 0) void'(buf_q.pop_front());
      end
      if (imem_resp_valid && mq.size() != 0) begin
        e = mq.pop_front();
        if (!redirect_valid && e.epoch == epoch) buf_q.push_back(e.exp_pc);
      end
      if (redirect_valid) begin
        buf_q.delete();
        epoch++;
        m_pc = {redirect_pc[31:2], 2'b00};
      end else if (c_req_valid && imem_req_ready) begin
        mq.push_back('{c_addr, m_pc, cyc + int'($urandom_range(lat_max - 1, 0)), epoch});
        acc_log.push_back(c_addr);
        m_pc = m_pc + 32'd4;
        accepts++;
      end
    end
    #1;
    if (mq.size() != 0 && mq[0].earliest <= cyc && int'($urandom_range(99, 0)) < resp_pct) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(mq[0].mem_addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'hDEAD_BEEF;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    bit found;
    int acc0;
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    imem_req_ready = 1'b1; inst_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    m_pc = RPC; m_boot = 1'b1; m_mis = 1'b0;
    epoch = 0; cyc = 0; lat_max = 1; resp_pct = 100;
    errors = 0; checks = 0; accepts = 0; mis_pulses = 0; first_iv = -1;
    run(3);

    // Reset release with a 1-cycle memory
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (c_inst_valid && first_iv < 0) first_iv = i;
    end
    chk("first_inst_latency", 32'(first_iv), 32'd3);
    run(10);

    // Mid-stream reset, then decode backpressure from an empty pipeline
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1; inst_ready = 1'b0;
    acc0 = accepts;
    run(12);
    chk("stall_requests", 32'(accepts - acc0), 32'(DEPTH));
    chk("stall_pc_frozen", imem_req_addr, RPC + 32'(4 * DEPTH));
    inst_ready = 1'b1;
    run(12);

    // Redirect with two responses held in flight
    resp_pct = 0;
    run(4);
    resp_pct = 100;
    pop_log.delete();
    redirect_to(32'h0000_0100);
    run(10);
    chk_log("redirect_first_pc", 1'b0, 0, 32'h0000_0100);

    // Redirect in the same cycle as a response and a pop
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      found = imem_resp_valid && (buf_q.size() != 0);
    end
    chk("found_overlap", {31'd0, found}, 32'd1);
    pop_log.delete();
    redirect_to(32'h0000_0300);
    run(8);
    chk_log("overlap_first_pc", 1'b0, 0, 32'h0000_0300);

    // Misaligned redirect
    mis_pulses = 0; pop_log.delete(); acc_log.delete();
    redirect_to(32'h0000_0203);
    run(6);
    chk("misalign_pulses", 32'(mis_pulses), 32'd1);
    chk_log("misalign_req_addr", 1'b1, 0, 32'h0000_0200);

    // Back-to-back redirects: last one wins
    pop_log.delete();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    cycle();
    redirect_to(32'h0000_0500);
    run(8);
    chk_log("b2b_first_pc", 1'b0, 0, 32'h0000_0500);

    // PC wrap at the top of the address space
    acc_log.delete();
    redirect_to(32'hFFFF_FFF8);
    run(12);
    chk_log("wrap_addr0", 1'b1, 0, 32'hFFFF_FFF8);
    chk_log("wrap_addr2", 1'b1, 2, 32'h0000_0000);

    // Random traffic: stalls, variable latency, redirects and resets
    lat_max = 3; resp_pct = 70;
    for (int i = 0; i < 2000; i++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(199, 0) == 0) rst_n = 1'b0;
      else rst_n = 1'b1;
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(9, 0) < 7);
      redirect_pc    = $urandom & 32'h0000_0FFF;
      redirect_valid = rst_n && !m_boot && ($urandom_range(29, 0) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
